// File: rtl/vga_scan_driver.sv
// Raster scan engine: pixel counters, sync/blank generation and DAC output registers.
// All DAC-side outputs lag DrawX/DrawY by one pixel so colour and sync stay aligned.
module vga_scan_driver #(
    parameter int unsigned PIX_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PIX_DIV / 2);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_TICK       = 10'(V_VISIBLE - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             blank_n_q, blank_n_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             vga_clk_q, vga_clk_d;
    logic             tick_q, tick_d;
    logic             pix_ce;
    logic             visible;

    always_comb begin
        pix_ce    = (div_q == DIV_LAST);
        div_d     = pix_ce ? '0 : div_q + 1'b1;
        visible   = (h_q < H_VIS) && (v_q < V_VIS);
        h_d       = h_q;
        v_d       = v_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        blank_n_d = blank_n_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        tick_d    = 1'b0;

        if (pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // Outputs sample the pixel being left, giving the one-pixel lag.
            r_d       = visible ? R_in : 8'h00;
            g_d       = visible ? G_in : 8'h00;
            b_d       = visible ? B_in : 8'h00;
            blank_n_d = visible;
            hs_d      = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
            vs_d      = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
            tick_d    = (h_q == H_LAST) && (v_q == V_TICK);
        end

        // High over the second half of each pixel so its rising edge is mid-pixel.
        vga_clk_d = (div_d >= DIV_HALF);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_n_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            vga_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            vga_clk_q <= vga_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;
    assign frame_tick  = tick_q;

endmodule
